// File: rtl/aes_spi_pkg.sv
// Shared definitions for the AES SPI frame link.
// Provides the frame FSM state encoding, the fixed message width,
// the key width helper and the core mode constants.
package aes_spi_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RX_MSG    = 3'd1,
    RX_KEY    = 3'd2,
    START     = 3'd3,
    WAIT_CORE = 3'd4,
    TX        = 3'd5,
    DONE      = 3'd6
  } state_t;

  localparam int unsigned MSG_BITS = 128;

  localparam logic ENCR = 1'b0;
  localparam logic DECR = 1'b1;

  // Key length in bits for a key of nk 32-bit words.
  function automatic int unsigned KEY_BITS(input int unsigned nk);
    return nk * 32;
  endfunction

endpackage

// File: rtl/aes_spi_frame_link_piso.sv
// 128-bit loadable right-shift register that drives MISO with bit 0.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear      : zero the register (line returns to 0)
//   load       : capture din in parallel
//   shift      : shift right by one, zero filled
//   din        : parallel load value
//   dout       : current bit 0
import aes_spi_pkg::*;

module spi_piso_128 (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                load,
  input  logic                shift,
  input  logic [MSG_BITS-1:0] din,
  output logic                dout
);

  logic [MSG_BITS-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {1'b0, sr[MSG_BITS-1:1]};
    end
  end

  assign dout = sr[0];

endmodule

// File: rtl/aes_spi_frame_link.sv
// Serial front-end for the AES slave: deserialises a 128-bit block and an
// NK*32-bit key (LSB first), starts the AES core, waits for completion and
// serialises the 128-bit result back on MISO (LSB first).
// Ports:
//   clk, reset         : clock and synchronous active-high reset
//   cs_n, bit_en, mosi : SPI frame select, bit strobe and serial input
//   mode_in            : 0 encrypt / 1 decrypt, sampled at frame start
//   miso               : serial result output
//   core_start/mode/data/key : request to the AES core
//   core_done, core_result   : completion handshake from the AES core
//   busy, frame_done, err_abort : status
import aes_spi_pkg::*;

module aes_spi_frame_link #(
  parameter int unsigned NK    = 4,
  parameter int unsigned BLK_W = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cs_n,
  input  logic               bit_en,
  input  logic               mosi,
  input  logic               mode_in,
  output logic               miso,
  output logic               core_start,
  output logic               core_mode,
  output logic [BLK_W-1:0]   core_data,
  output logic [NK*32-1:0]   core_key,
  input  logic               core_done,
  input  logic [BLK_W-1:0]   core_result,
  output logic               busy,
  output logic               frame_done,
  output logic               err_abort
);

  localparam int unsigned KBITS    = KEY_BITS(NK);
  localparam int unsigned MIW      = $clog2(BLK_W);
  localparam int unsigned KIW      = $clog2(KBITS);
  localparam logic [8:0]  MSG_LAST = 9'(BLK_W - 1);
  localparam logic [8:0]  KEY_LAST = 9'(KBITS - 1);

  state_t     state;
  logic [8:0] cnt;
  logic       tx_load;
  logic       tx_shift;
  logic       tx_clear;

  // Shift register control. The final TX strobe does not shift so that
  // MISO keeps presenting the last result bit while in DONE.
  always_comb begin
    tx_load  = (state == WAIT_CORE) && core_done;
    tx_shift = (state == TX) && !cs_n && bit_en && (cnt != MSG_LAST);
    tx_clear = ((state == DONE) || (state == TX)) && cs_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      core_mode <= 1'b0;
      core_data <= '0;
      core_key  <= '0;
      err_abort <= 1'b0;
    end else begin
      err_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (!cs_n) begin
            core_mode <= mode_in;
            cnt       <= '0;
            state     <= RX_MSG;
          end
        end
        RX_MSG: begin
          if (cs_n) begin
            state     <= IDLE;
            err_abort <= 1'b1;
          end else if (bit_en) begin
            core_data[cnt[MIW-1:0]] <= mosi;
            if (cnt == MSG_LAST) begin
              cnt   <= '0;
              state <= RX_KEY;
            end else begin
              cnt <= cnt + 9'd1;
            end
          end
        end
        RX_KEY: begin
          if (cs_n) begin
            state     <= IDLE;
            err_abort <= 1'b1;
          end else if (bit_en) begin
            core_key[cnt[KIW-1:0]] <= mosi;
            if (cnt == KEY_LAST) begin
              state <= START;
            end else begin
              cnt <= cnt + 9'd1;
            end
          end
        end
        START: begin
          state <= WAIT_CORE;
        end
        WAIT_CORE: begin
          if (core_done) begin
            cnt <= '0;
            if (cs_n) begin
              state     <= IDLE;
              err_abort <= 1'b1;
            end else begin
              state <= TX;
            end
          end
        end
        TX: begin
          if (cs_n) begin
            state     <= IDLE;
            err_abort <= 1'b1;
          end else if (bit_en) begin
            if (cnt == MSG_LAST) begin
              state <= DONE;
            end else begin
              cnt <= cnt + 9'd1;
            end
          end
        end
        DONE: begin
          if (cs_n) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign core_start = (state == START);
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  spi_piso_128 u_piso (
    .clk   (clk),
    .reset (reset),
    .clear (tx_clear),
    .load  (tx_load),
    .shift (tx_shift),
    .din   (core_result),
    .dout  (miso)
  );

endmodule

// File: tb/tb_aes_spi_frame_link.sv
import aes_spi_pkg::*;

module tb_aes_spi_frame_link;

  typedef struct {
    logic         nk8;
    logic         mode;
    logic [127:0] msg;
    logic [255:0] key;
    int unsigned  period;
    logic [127:0] result;
    int unsigned  core_lat;
    logic         exp_mode;
    logic [127:0] exp_data;
    logic [255:0] exp_key;
    logic [127:0] exp_miso;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, cs_n4, cs_n8, bit_en, mosi, mode_in, core_done;
  logic [127:0] core_result;

  logic         miso4, core_start4, core_mode4, busy4, frame_done4, err_abort4;
  logic [127:0] core_data4, core_key4;
  logic         miso8, core_start8, core_mode8, busy8, frame_done8, err_abort8;
  logic [127:0] core_data8;
  logic [255:0] core_key8;

  aes_spi_frame_link #(.NK(4), .BLK_W(128)) dut4 (
    .clk(clk), .reset(reset), .cs_n(cs_n4), .bit_en(bit_en), .mosi(mosi),
    .mode_in(mode_in), .miso(miso4), .core_start(core_start4),
    .core_mode(core_mode4), .core_data(core_data4), .core_key(core_key4),
    .core_done(core_done), .core_result(core_result), .busy(busy4),
    .frame_done(frame_done4), .err_abort(err_abort4)
  );

  aes_spi_frame_link #(.NK(8), .BLK_W(128)) dut8 (
    .clk(clk), .reset(reset), .cs_n(cs_n8), .bit_en(bit_en), .mosi(mosi),
    .mode_in(mode_in), .miso(miso8), .core_start(core_start8),
    .core_mode(core_mode8), .core_data(core_data8), .core_key(core_key8),
    .core_done(core_done), .core_result(core_result), .busy(busy8),
    .frame_done(frame_done8), .err_abort(err_abort8)
  );

  logic         sel8;
  logic         miso_s, start_s, mode_s, busy_s, fdone_s;
  logic [127:0] data_s;
  logic [255:0] key_s;
  assign miso_s  = sel8 ? miso8 : miso4;
  assign start_s = sel8 ? core_start8 : core_start4;
  assign mode_s  = sel8 ? core_mode8 : core_mode4;
  assign busy_s  = sel8 ? busy8 : busy4;
  assign fdone_s = sel8 ? frame_done8 : frame_done4;
  assign data_s  = sel8 ? core_data8 : core_data4;
  assign key_s   = sel8 ? core_key8 : {128'b0, core_key4};

  int n_pass  = 0;
  int n_total = 0;
  int starts4 = 0, starts8 = 0, aborts4 = 0, aborts8 = 0;

  always @(negedge clk) begin
    if (core_start4) starts4++;
    if (core_start8) starts8++;
    if (err_abort4)  aborts4++;
    if (err_abort8)  aborts8++;
  end

  vec_t vecs[5];

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one complete frame; stops after tx_stop output bits when tx_stop < 128.
  task automatic run_frame(input vec_t v, input int unsigned tx_stop);
    int           s0, a0, kb;
    logic [127:0] rx;
    sel8 = v.nk8;
    kb   = v.nk8 ? 256 : 128;
    s0   = v.nk8 ? starts8 : starts4;
    a0   = v.nk8 ? aborts8 : aborts4;
    rx   = '0;
    mode_in = v.mode;
    bit_en  = 1'b0;
    if (v.nk8) cs_n8 = 1'b0; else cs_n4 = 1'b0;
    tick();
    mode_in = ~v.mode;
    check("busy_rx", 256'(busy_s), 256'(1'b1));
    for (int i = 0; i < 128 + kb; i++) begin
      repeat (v.period - 1) begin
        bit_en = 1'b0;
        mosi   = 1'($urandom);
        tick();
      end
      bit_en = 1'b1;
      mosi   = (i < 128) ? v.msg[i] : v.key[i-128];
      tick();
    end
    bit_en = 1'b0;
    check("start_latency", 256'(start_s), 256'(1'b1));
    check("core_data", 256'(data_s), 256'(v.exp_data));
    check("core_key", key_s, v.exp_key);
    check("core_mode", 256'(mode_s), 256'(v.exp_mode));
    tick();
    check("start_one_cycle", 256'(start_s), 256'(1'b0));
    repeat (v.core_lat - 1) tick();
    core_done   = 1'b1;
    core_result = v.result;
    tick();
    core_done   = 1'b0;
    core_result = {$urandom, $urandom, $urandom, $urandom};
    check("miso_bit0", 256'(miso_s), 256'(v.exp_miso[0]));
    for (int i = 0; i < 128; i++) begin
      if (i == int'(tx_stop)) return;
      repeat (v.period - 1) begin
        bit_en = 1'b0;
        tick();
      end
      bit_en = 1'b1;
      rx[i]  = miso_s;
      tick();
    end
    bit_en = 1'b0;
    check("miso_stream", 256'(rx), 256'(v.exp_miso));
    check("frame_done", 256'(fdone_s), 256'(1'b1));
    check("miso_hold_last", 256'(miso_s), 256'(v.exp_miso[127]));
    cs_n4 = 1'b1;
    cs_n8 = 1'b1;
    tick();
    check("frame_done_clr", 256'(fdone_s), 256'(1'b0));
    check("busy_idle", 256'(busy_s), 256'(1'b0));
    check("miso_idle", 256'(miso_s), 256'(1'b0));
    check("start_count", 256'(v.nk8 ? starts8 : starts4), 256'(s0 + 1));
    check("abort_count", 256'(v.nk8 ? aborts8 : aborts4), 256'(a0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] amsg;
    logic [127:0] aexp;
    reset = 1'b1; cs_n4 = 1'b1; cs_n8 = 1'b1; bit_en = 1'b0; mosi = 1'b0;
    mode_in = 1'b0; core_done = 1'b0; core_result = '0; sel8 = 1'b0;

    vecs[0] = '{nk8: 1'b0, mode: ENCR, period: 1, core_lat: 11, exp_mode: ENCR,
                msg: 128'h3243f6a8885a308d313198a2e0370734,
                key: {128'b0, 128'h2b7e151628aed2a6abf7158809cf4f3c},
                result: 128'h3925841d02dc09fbdc118597196a0b32,
                exp_data: 128'h3243f6a8885a308d313198a2e0370734,
                exp_key: {128'b0, 128'h2b7e151628aed2a6abf7158809cf4f3c},
                exp_miso: 128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = vecs[0];
    vecs[1].period = 5;
    vecs[2] = '{nk8: 1'b1, mode: ENCR, period: 1, core_lat: 11, exp_mode: ENCR,
                msg: 128'h00112233445566778899aabbccddeeff,
                key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                result: 128'h8ea2b7ca516745bfeafc49904b496089,
                exp_data: 128'h00112233445566778899aabbccddeeff,
                exp_key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                exp_miso: 128'h8ea2b7ca516745bfeafc49904b496089};
    vecs[3] = '{nk8: 1'b0, mode: DECR, period: 1, core_lat: 4, exp_mode: DECR,
                msg: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                key: {128'b0, 128'h000102030405060708090a0b0c0d0e0f},
                result: 128'h00112233445566778899aabbccddeeff,
                exp_data: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                exp_key: {128'b0, 128'h000102030405060708090a0b0c0d0e0f},
                exp_miso: 128'h00112233445566778899aabbccddeeff};
    vecs[4] = '{nk8: 1'b0, mode: ENCR, period: 1, core_lat: 2, exp_mode: ENCR,
                msg: 128'h00112233445566778899aabbccddeeff,
                key: {128'b0, 128'h000102030405060708090a0b0c0d0e0f},
                result: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                exp_data: 128'h00112233445566778899aabbccddeeff,
                exp_key: {128'b0, 128'h000102030405060708090a0b0c0d0e0f},
                exp_miso: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};

    // Reset state of both instances.
    tick();
    tick();
    check("rst_outputs4", 256'({miso4, core_start4, core_mode4, busy4, frame_done4, err_abort4}), '0);
    check("rst_data4", 256'(core_data4), '0);
    check("rst_key4", 256'(core_key4), '0);
    check("rst_outputs8", 256'({miso8, core_start8, core_mode8, busy8, frame_done8, err_abort8}), '0);
    check("rst_key8", core_key8, '0);
    reset = 1'b0;
    tick();

    // Abort after 50 message bits; the strobe coinciding with cs_n=1 is discarded.
    amsg  = 128'hfedcba9876543210f0e1d2c3b4a59687;
    aexp  = amsg & ((128'd1 << 50) - 128'd1);
    cs_n4 = 1'b0;
    tick();
    for (int i = 0; i < 50; i++) begin
      bit_en = 1'b1;
      mosi   = amsg[i];
      tick();
    end
    cs_n4  = 1'b1;
    bit_en = 1'b1;
    mosi   = 1'b1;
    tick();
    bit_en = 1'b0;
    check("abort_pulse", 256'(err_abort4), 256'(1'b1));
    check("abort_idle", 256'(busy4), 256'(1'b0));
    check("abort_partial_data", 256'(core_data4), 256'(aexp));
    tick();
    check("abort_pulse_end", 256'(err_abort4), 256'(1'b0));
    check("abort_count", 256'(aborts4), 256'(1));
    check("abort_no_start", 256'(starts4), 256'(0));

    // Table-driven frames: FIPS NK=4, sparse strobes, NK=8, back-to-back modes.
    for (int k = 0; k < 5; k++) run_frame(vecs[k], 128);

    // Reset after 64 output bits.
    run_frame(vecs[0], 64);
    reset  = 1'b1;
    bit_en = 1'b0;
    tick();
    check("rst_tx_miso", 256'(miso4), 256'(1'b0));
    check("rst_tx_busy", 256'(busy4), 256'(1'b0));
    check("rst_tx_fdone", 256'(frame_done4), 256'(1'b0));
    check("rst_tx_abort", 256'(err_abort4), 256'(1'b0));
    reset = 1'b0;
    cs_n4 = 1'b1;
    tick();
    check("rst_tx_no_abort", 256'(aborts4), 256'(1));
    check("rst_tx_still_idle", 256'(busy4), 256'(1'b0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/aes_spi_frame_link.md
Name: aes_spi_frame_link

Overview:
Serial front-end for the AES slave, directly downstream of the SPI master's MOSI/CS/mode lines.
- Deserialises one frame (128-bit block, then NK*32-bit key) into parallel registers.
- Starts the AES core and waits for its completion handshake.
- Serialises the 128-bit result back on MISO.
- Sits between the SPI pins and the AES round engine.

Parameters:
NK, 4, key length in 32-bit words; legal values 4, 6, 8.
BLK_W, 128, block width in bits; fixed at 128.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
cs_n  input  1  chip select, active low; frame active while 0
bit_en  input  1  serial bit strobe; one bit transferred per clk with bit_en=1
mosi  input  1  serial data in, LSB first
mode_in  input  1  0=encrypt, 1=decrypt; sampled at frame start
miso  output  1  serial result out, LSB first
core_start  output  1  one-cycle start pulse to AES core
core_mode  output  1  latched mode to core
core_data  output  BLK_W  latched block to core
core_key  output  NK*32  latched key to core
core_done  input  1  AES core completion, level or pulse
core_result  input  BLK_W  AES result, valid when core_done=1
busy  output  1  high in any state except IDLE
frame_done  output  1  high while in DONE
err_abort  output  1  one-cycle pulse on aborted frame

Behaviour:
Reset values:
- All outputs 0; bit counter 0; state IDLE.
- core_data and core_key are cleared to 0.
- Reset mid-frame returns to IDLE on the next edge; no err_abort pulse.

Bit counter: 9 bits, enough for 256 key bits.

State machine:
- IDLE: when cs_n=0, latch mode_in into core_mode, clear counter, go to RX_MSG. bit_en is ignored in this cycle.
- RX_MSG: on each bit_en, core_data[cnt] <= mosi and cnt++. On the bit_en with cnt=127, clear cnt and go to RX_KEY.
- RX_KEY: on each bit_en, core_key[cnt] <= mosi and cnt++. On the bit_en with cnt=NK*32-1, go to START.
- START: core_start=1 for exactly this one cycle, then go to WAIT_CORE.
- WAIT_CORE: bit_en and cs_n are ignored. On core_done=1, load core_result into the tx shift register, set miso=core_result[0] and cnt=0.
  - If cs_n=1 in that same cycle: pulse err_abort and go to IDLE.
  - Otherwise go to TX.
- TX: miso always shows tx_sr[0].
  - On each bit_en, shift tx_sr right and cnt++.
  - On the bit_en with cnt=127, go to DONE; miso holds the last bit.
- DONE: frame_done=1. When cs_n=1, go to IDLE, set miso=0 and clear frame_done.

Abort and hold rules:
- cs_n=1 in RX_MSG, RX_KEY or TX: go to IDLE next cycle with err_abort=1 for one cycle.
  - Partial core_data/core_key are kept, not cleared.
  - core_start is never issued.
- Simultaneous bit_en=1 and cs_n=1 in RX/TX: abort wins and the bit is discarded.
- core_data, core_key and core_mode stay stable from START until the next frame start.

Latency:
- Last key bit_en to core_start: 1 cycle.
- core_done to miso showing bit 0: 1 cycle.

Decomposition:
- Package aes_spi_pkg holds:
  - state enum {IDLE, RX_MSG, RX_KEY, START, WAIT_CORE, TX, DONE}
  - localparams MSG_BITS=128 and KEY_BITS(NK)=NK*32
  - mode constants ENCR=0 and DECR=1
- One sub-module is natural: spi_piso_128, the loadable 128-bit right-shift register with shift enable that drives miso. Deserialisation stays inline.

Test Plan:
1. FIPS-197 encrypt, NK=4:
   - Stimulus: mode_in=0; stream msg 3243f6a8885a308d313198a2e0370734 then key 2b7e151628aed2a6abf7158809cf4f3c, bit_en every cycle.
   - Required: core_start pulses once; core_data/core_key match exactly.
   - Then: model core returns 3925841d02dc09fbdc118597196a0b32 after 11 cycles. miso emits that value LSB first over 128 bit_en; frame_done=1.
2. Sparse strobes:
   - Stimulus: same frame with bit_en high 1 cycle in 5.
   - Required: identical core_data/core_key/miso sequence; no bit double-counted.
3. Abort mid-message:
   - Stimulus: cs_n=1 after 50 message bits.
   - Required: err_abort high exactly 1 cycle; state IDLE; core_start never asserted; next full frame succeeds.
4. NK=8:
   - Stimulus: 256-bit key 000102…1f.
   - Required: core_key matches; core_start 1 cycle after the 384th bit_en.
5. Reset during TX:
   - Stimulus: reset after 64 output bits.
   - Required: next edge has miso=0, busy=0, frame_done=0, err_abort=0.
6. Back-to-back frames and mode:
   - Stimulus: frame 1 with mode_in=1, cs_n high 1 cycle, then frame 2 with mode_in=0.
   - Required: core_mode=1 then 0; each frame gives exactly one core_start.
